// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter collecting results from NUM_FU functional units
// into one holding slot each and broadcasting one result per cycle on the
// common data bus (register-file write port + wakeup tag), round-robin.
//
// Ports:
//   clk          clock, all state on posedge
//   rst          synchronous active-high reset
//   flush_i      mispredict squash, drops buffered and outgoing results
//   fu_valid_i   per-FU result valid
//   fu_tag_i     per-FU destination physical tag
//   fu_data_i    per-FU 64-bit result
//   fu_ready_o   per-FU accept (combinational)
//   cdb_valid_o  registered broadcast valid
//   cdb_tag_o    registered broadcast tag
//   cdb_data_o   registered broadcast data

`ifndef PRF_IDX_W
`define PRF_IDX_W 7
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif

module wb_arbiter #(
   parameter int unsigned        NUM_FU   = 4,
   parameter int unsigned        IDX_W    = `PRF_IDX_W,
   parameter logic [IDX_W-1:0]   ZERO_TAG = IDX_W'(`ZERO_REG),
   localparam int unsigned       DATA_W   = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush_i,
   input  logic [NUM_FU-1:0]                fu_valid_i,
   input  logic [NUM_FU-1:0][IDX_W-1:0]     fu_tag_i,
   input  logic [NUM_FU-1:0][DATA_W-1:0]    fu_data_i,
   output logic [NUM_FU-1:0]                fu_ready_o,
   output logic                             cdb_valid_o,
   output logic [IDX_W-1:0]                 cdb_tag_o,
   output logic [DATA_W-1:0]                cdb_data_o
);

   localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0]               r_slot_vld;
   logic [NUM_FU-1:0][IDX_W-1:0]    r_slot_tag;
   logic [NUM_FU-1:0][DATA_W-1:0]   r_slot_data;
   logic [PTR_W-1:0]                r_rr_ptr;

   logic                            w_gnt_vld;
   logic [PTR_W-1:0]                w_gnt_idx;
   logic [NUM_FU-1:0]               w_gnt_oh;
   logic [PTR_W-1:0]                w_rr_nxt;
   logic [NUM_FU-1:0]               w_load;

   // Round-robin search over occupied slots starting at r_rr_ptr
   always_comb begin : grant_search
      logic [PTR_W:0] v_cand;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_gnt_oh  = '0;
      v_cand    = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         v_cand = (PTR_W+1)'(r_rr_ptr) + (PTR_W+1)'(i);
         if (v_cand >= (PTR_W+1)'(NUM_FU)) begin
            v_cand = v_cand - (PTR_W+1)'(NUM_FU);
         end
         if (!w_gnt_vld && r_slot_vld[v_cand[PTR_W-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = v_cand[PTR_W-1:0];
         end
      end
      if (w_gnt_vld) begin
         w_gnt_oh[w_gnt_idx] = 1'b1;
      end
   end

   // Pointer moves just past the winner, wrapping at NUM_FU
   assign w_rr_nxt = (32'(w_gnt_idx) == NUM_FU - 1) ? '0 : w_gnt_idx + PTR_W'(1);

   // A slot can take a new result if empty or draining this cycle; reset forces accept
   assign fu_ready_o = {NUM_FU{rst}} |
                       ({NUM_FU{~flush_i}} & (~r_slot_vld | w_gnt_oh));

   // Zero-register results are accepted but dropped on the floor
   always_comb begin
      w_load = '0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         w_load[k] = fu_valid_i[k] & fu_ready_o[k] & (fu_tag_i[k] != ZERO_TAG);
      end
   end

   // Slot, pointer and broadcast registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_vld  <= '0;
         r_rr_ptr    <= '0;
         cdb_valid_o <= 1'b0;
         cdb_tag_o   <= '0;
         cdb_data_o  <= '0;
      end else if (flush_i) begin
         r_slot_vld  <= '0;
         cdb_valid_o <= 1'b0;
      end else begin
         cdb_valid_o <= w_gnt_vld;
         if (w_gnt_vld) begin
            cdb_tag_o  <= r_slot_tag[w_gnt_idx];
            cdb_data_o <= r_slot_data[w_gnt_idx];
            r_rr_ptr   <= w_rr_nxt;
         end
         // A new load wins over the drain of the same slot
         for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (w_load[k]) begin
               r_slot_vld[k]  <= 1'b1;
               r_slot_tag[k]  <= fu_tag_i[k];
               r_slot_data[k] <= fu_data_i[k];
            end else if (w_gnt_oh[k]) begin
               r_slot_vld[k]  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit result producers (2..8).
REQ-002 Parameter IDX_W, default `PRF_IDX_W, physical register tag width.
REQ-003 Parameter ZERO_TAG, default `ZERO_REG, tag of the hardwired-zero physical register.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush_i  input  1  mispredict squash; discards all buffered and outgoing results.
REQ-007 fu_valid_i  input  NUM_FU  per-FU result valid.
REQ-008 fu_tag_i  input  NUM_FU x IDX_W  per-FU destination physical tag.
REQ-009 fu_data_i  input  NUM_FU x 64  per-FU result data.
REQ-010 fu_ready_o  output  NUM_FU  per-FU accept; a transfer occurs when fu_valid_i[k] & fu_ready_o[k].
REQ-011 cdb_valid_o  output  1  registered broadcast valid; drives physical register file write enable.
REQ-012 cdb_tag_o  output  IDX_W  registered broadcast tag; drives write index and wakeup tag.
REQ-013 cdb_data_o  output  64  registered broadcast data; drives write data.

Function
REQ-014 One holding slot per FU (valid bit, tag, data); a transfer loads slot k at the clock edge.
REQ-015 fu_ready_o[k] = !flush_i & (slot k empty | slot k granted this cycle); purely combinational, no dependence on fu_valid_i.
REQ-016 Same-cycle grant and new transfer on slot k: slot k holds the new result next cycle, valid stays 1.
REQ-017 Arbiter grants at most one occupied slot per cycle, round-robin: search starts at index rr_ptr, wraps NUM_FU-1 -> 0.
REQ-018 On a grant to slot g, rr_ptr <= (g+1) mod NUM_FU; no grant -> rr_ptr unchanged.
REQ-019 Granted slot's tag/data load cdb_tag_o/cdb_data_o at the edge; cdb_valid_o <= 1 next cycle.
REQ-020 No grant -> cdb_valid_o <= 0; cdb_tag_o/cdb_data_o hold last value.
REQ-021 Latency: FU transfer at edge t, earliest cdb_valid_o high in cycle after edge t+1 (2 cycles) when uncontended.
REQ-022 Transfer with fu_tag_i == ZERO_TAG: accepted (ready honoured), never loaded into a slot, never broadcast, no rr_ptr change.
REQ-023 Starvation bound: an occupied slot is granted within NUM_FU cycles of becoming occupied.
REQ-024 Throughput: one broadcast per cycle sustained while any slot occupied.
REQ-025 flush_i high at an edge: all slot valids <= 0, cdb_valid_o <= 0, rr_ptr unchanged, fu_valid_i ignored that cycle.
REQ-026 flush_i and rst together: rst takes precedence.
REQ-027 No result is duplicated or lost except by flush_i or ZERO_TAG discard.

Reset
REQ-028 rst high at an edge: all slot valids 0, rr_ptr 0, cdb_valid_o 0, cdb_tag_o 0, cdb_data_o 0.
REQ-029 While rst high, fu_ready_o = 1 for all k and inputs are ignored; rst mid-operation drops all buffered results.

Verification
REQ-030 Single FU1 result tag 5 data 0xDEAD at edge 0 -> cdb_valid_o=1, tag 5, data 0xDEAD in cycle after edge 1, only that cycle.
REQ-031 FU0..FU3 all valid same cycle, tags 10..13, rr_ptr=0 -> broadcasts tags 10,11,12,13 on four consecutive cycles, rr_ptr ends 0.
REQ-032 FU2 held valid every cycle, ready honoured, with FU0 valid once -> FU0 broadcast within 4 cycles; FU2 stream one per cycle otherwise.
REQ-033 FU0 tag ZERO_TAG data 0x1234 -> fu_ready_o[0]=1, no cdb_valid_o pulse, rr_ptr unchanged.
REQ-034 Three slots occupied, flush_i pulsed one cycle -> cdb_valid_o=0 next cycle, no buffered tag ever broadcast, fu_ready_o all 1 after.
REQ-035 rst asserted with slots occupied and cdb_valid_o=1 -> next cycle cdb_valid_o=0, tag 0, data 0, rr_ptr 0.
